secuenciador_motores: RTL

- Downstream of the RGB memory: consumes the three latched cycle counts (R, G, B, 5 bits each) and drives the three dispensing motors one after another.
- Each motor runs for its programmed number of time ticks. Per-colour completion flags go back to the control FSM and clear the memory.
- Generates its own tick from the single system clock. No derived clock domains.

---
 rtl/secuenciador_motores.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/secuenciador_motores.sv
// secuenciador_motores: drives the R, G and B dispensing motors one after the
// other for their latched tick counts, reporting per-colour completion flags.
// A tick is TICK_DIV clk cycles, produced by an internal prescaler.
// Optional build macro MOTOR_PAUSE_EN adds the `pausa` input, which freezes
// the running phase (motor off, counters held) until released.
//
// Control handshake: start and abort are single-cycle synchronous requests
// with no ready/acknowledge; start is honoured only in IDLE or DONE, abort in
// any state, and abort wins when both are high in the same cycle.
//
// Debug: `estado` mirrors the FSM state (IDLE=0, LOAD=1, RUN_R=2, RUN_G=3,
// RUN_B=4, DONE=5).
module secuenciador_motores #(
  parameter int CNT_W    = 5,
  parameter int TICK_DIV = 20000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
`ifdef MOTOR_PAUSE_EN
  input  logic             pausa,
`endif
  input  logic [CNT_W-1:0] ciclos_R,
  input  logic [CNT_W-1:0] ciclos_G,
  input  logic [CNT_W-1:0] ciclos_B,
  output logic [2:0]       Motores,
  output logic [2:0]       flags,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] restantes,
  output logic [2:0]       estado
);

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN_R = 3'd2,
    RUN_G = 3'd3,
    RUN_B = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] snap_r, snap_g, snap_b;

  logic             hold;
  logic             go_r, go_g, go_b;
  state_t           nxt_state;
  logic [2:0]       nxt_flags;
  logic [2:0]       nxt_mot;
  logic [CNT_W-1:0] nxt_cnt;
  logic [2:0]       run_mot;

`ifdef MOTOR_PAUSE_EN
  assign hold = pausa;
`else
  assign hold = 1'b0;
`endif

  assign estado = state;

  // Next phase after the current one: first later colour with a nonzero
  // count; flags cover every colour before it (finished or skipped).
  always_comb begin
    go_r      = (state == LOAD) && (snap_r != '0);
    go_g      = ((state == LOAD) || (state == RUN_R)) && (snap_g != '0);
    go_b      = ((state == LOAD) || (state == RUN_R) || (state == RUN_G)) && (snap_b != '0);
    nxt_state = DONE;
    nxt_flags = 3'b111;
    nxt_mot   = 3'b000;
    nxt_cnt   = '0;
    if (go_r) begin
      nxt_state = RUN_R;
      nxt_flags = 3'b000;
      nxt_mot   = 3'b001;
      nxt_cnt   = snap_r;
    end else if (go_g) begin
      nxt_state = RUN_G;
      nxt_flags = 3'b001;
      nxt_mot   = 3'b010;
      nxt_cnt   = snap_g;
    end else if (go_b) begin
      nxt_state = RUN_B;
      nxt_flags = 3'b011;
      nxt_mot   = 3'b100;
      nxt_cnt   = snap_b;
    end
  end

  // Motor enable belonging to the phase currently running.
  always_comb begin
    run_mot = 3'b000;
    case (state)
      RUN_R:   run_mot = 3'b001;
      RUN_G:   run_mot = 3'b010;
      RUN_B:   run_mot = 3'b100;
      default: run_mot = 3'b000;
    endcase
  end

  // Sequencer FSM with registered outputs, prescaler and snapshot registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      presc     <= '0;
      snap_r    <= '0;
      snap_g    <= '0;
      snap_b    <= '0;
      Motores   <= 3'b000;
      flags     <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      restantes <= '0;
    end else if (abort) begin
      state     <= IDLE;
      presc     <= '0;
      Motores   <= 3'b000;
      flags     <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      restantes <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state  <= LOAD;
            snap_r <= ciclos_R;
            snap_g <= ciclos_G;
            snap_b <= ciclos_B;
            flags  <= 3'b000;
            presc  <= '0;
            busy   <= 1'b1;
          end
        end
        LOAD: begin
          state     <= nxt_state;
          flags     <= nxt_flags;
          Motores   <= nxt_mot;
          restantes <= nxt_cnt;
          presc     <= '0;
          if (nxt_state == DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        RUN_R, RUN_G, RUN_B: begin
          if (hold) begin
            Motores <= 3'b000;
          end else if (presc == TICK_LAST) begin
            presc <= '0;
            if (restantes == CNT_W'(1)) begin
              // Gapless handoff: old enable drops and new one rises together.
              state     <= nxt_state;
              flags     <= nxt_flags;
              Motores   <= nxt_mot;
              restantes <= nxt_cnt;
              if (nxt_state == DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
              end
            end else begin
              restantes <= restantes - CNT_W'(1);
              Motores   <= run_mot;
            end
          end else begin
            presc   <= presc + PW'(1);
            Motores <= run_mot;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
